// File: rtl/hazard_forward_unit.sv
// ID-stage hazard unit for the 5-stage RV32I pipeline: detects load-use stalls,
// selects operand forwarding sources and counts stall cycles.
module hazard_forward_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Branch_ID,
    input  logic             rs1use_ID,
    input  logic             rs2use_ID,
    input  logic [1:0]       hazard_optype_ID,
    input  logic [4:0]       rd_ID,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    output logic             PC_EN_IF,
    output logic             reg_FD_EN,
    output logic             reg_FD_flush,
    output logic             reg_DE_flush,
    output logic [1:0]       forward_ctrl_A,
    output logic [1:0]       forward_ctrl_B,
    output logic             forward_ctrl_ls,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_ALU   = 2'd1;
    localparam logic [1:0] OP_LOAD  = 2'd2;
    localparam logic [1:0] OP_STORE = 2'd3;

    localparam logic [1:0] FWD_RF      = 2'd0;
    localparam logic [1:0] FWD_EX_ALU  = 2'd1;
    localparam logic [1:0] FWD_MEM_ALU = 2'd2;
    localparam logic [1:0] FWD_MEM_LD  = 2'd3;

    logic [1:0]       optype_ex_q, optype_ex_d;
    logic [1:0]       optype_mem_q, optype_mem_d;
    logic [4:0]       rd_ex_q, rd_ex_d;
    logic [4:0]       rd_mem_q, rd_mem_d;
    logic [4:0]       rs2_ex_q, rs2_ex_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             ld_hit_rs1;
    logic             ld_hit_rs2;
    logic             stall;

    // Forwarding priority: youngest producer (EX) first, then MEM; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic       src_use,
        input logic [4:0] src,
        input logic [1:0] op_ex,
        input logic [4:0] rd_ex,
        input logic [1:0] op_mem,
        input logic [4:0] rd_mem
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src_use && (src != 5'd0)) begin
            if ((src == rd_ex) && (op_ex == OP_ALU))
                sel = FWD_EX_ALU;
            else if ((src == rd_mem) && (op_mem == OP_ALU))
                sel = FWD_MEM_ALU;
            else if ((src == rd_mem) && (op_mem == OP_LOAD))
                sel = FWD_MEM_LD;
        end
        return sel;
    endfunction

    always_comb begin
        ld_hit_rs1 = rs1use_ID && (rs1_ID == rd_ex_q);
        // Store data is picked up from MEM load data a cycle later, so stores don't stall on rs2.
        ld_hit_rs2 = rs2use_ID && (rs2_ID == rd_ex_q) && (hazard_optype_ID != OP_STORE);
        stall      = !rst && (optype_ex_q == OP_LOAD) && (rd_ex_q != 5'd0)
                     && (ld_hit_rs1 || ld_hit_rs2);
    end

    always_comb begin
        PC_EN_IF     = !stall;
        reg_FD_EN    = !stall;
        reg_DE_flush = stall;
        // A stalled branch re-resolves next cycle, so its flush is suppressed now.
        reg_FD_flush = Branch_ID && !stall;
    end

    always_comb begin
        forward_ctrl_A  = FWD_RF;
        forward_ctrl_B  = FWD_RF;
        forward_ctrl_ls = 1'b0;
        if (!rst) begin
            forward_ctrl_A  = fwd_sel(rs1use_ID, rs1_ID, optype_ex_q, rd_ex_q,
                                      optype_mem_q, rd_mem_q);
            forward_ctrl_B  = fwd_sel(rs2use_ID, rs2_ID, optype_ex_q, rd_ex_q,
                                      optype_mem_q, rd_mem_q);
            forward_ctrl_ls = (optype_ex_q == OP_STORE) && (optype_mem_q == OP_LOAD)
                              && (rs2_ex_q != 5'd0) && (rs2_ex_q == rd_mem_q);
        end
    end

    always_comb begin
        optype_ex_d  = stall ? OP_NONE : hazard_optype_ID;
        rd_ex_d      = stall ? 5'd0 : rd_ID;
        rs2_ex_d     = stall ? 5'd0 : rs2_ID;
        optype_mem_d = optype_ex_q;
        rd_mem_d     = rd_ex_q;
        stall_cnt_d  = stall_cnt_q;
        if (stall && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            optype_ex_q  <= OP_NONE;
            optype_mem_q <= OP_NONE;
            rd_ex_q      <= 5'd0;
            rd_mem_q     <= 5'd0;
            rs2_ex_q     <= 5'd0;
            stall_cnt_q  <= '0;
        end else begin
            optype_ex_q  <= optype_ex_d;
            optype_mem_q <= optype_mem_d;
            rd_ex_q      <= rd_ex_d;
            rd_mem_q     <= rd_mem_d;
            rs2_ex_q     <= rs2_ex_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Sits in the ID stage of the 5-stage RV32I pipeline, directly downstream of the instruction decoder.
- Consumes the decoder's rs1use/rs2use, hazard_optype and taken-branch (Branch) signals, plus register indices from the ID stage.
- Internally tracks hazard_optype, rd and rs2 of the instructions in EX and MEM.
- Produces pipeline-register enables/flushes, forwarding selects and a saturating load-use stall counter.

Parameters:
CNT_W, 16, width of the stall_cnt performance counter (saturating).

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
Branch_ID  input  1  decoder Branch (jump or taken branch in ID)
rs1use_ID  input  1  decoder rs1use
rs2use_ID  input  1  decoder rs2use
hazard_optype_ID  input  2  decoder optype: 0 none, 1 ALU, 2 LOAD, 3 STORE
rd_ID  input  5  destination register index of ID instruction
rs1_ID  input  5  source 1 index of ID instruction
rs2_ID  input  5  source 2 index of ID instruction
PC_EN_IF  output  1  PC update enable
reg_FD_EN  output  1  IF/ID register enable
reg_FD_flush  output  1  IF/ID register flush (insert NOP)
reg_DE_flush  output  1  ID/EX register flush (bubble)
forward_ctrl_A  output  2  rs1 operand select: 0 regfile, 1 EX ALU result, 2 MEM ALU result, 3 MEM load data
forward_ctrl_B  output  2  rs2 operand select, same encoding
forward_ctrl_ls  output  1  store in EX takes its store data from load data in MEM
stall_cnt  output  CNT_W  number of load-use stall cycles since reset

Behaviour:
- Internal state: optype_EX, optype_MEM (2b); rd_EX, rd_MEM (5b); rs2_EX (5b); stall_cnt.
- Reset (async, rst=1): all internal state and stall_cnt cleared to 0 immediately.
- Outputs are combinational from ID inputs and internal state.
  - Under reset: PC_EN_IF=1, reg_FD_EN=1, reg_DE_flush=0, forward selects 0, forward_ctrl_ls=0.
  - reg_FD_flush equals Branch_ID.
- Each rising edge (rst=0):
  - optype_EX<=stall?0:hazard_optype_ID; rd_EX<=stall?0:rd_ID; rs2_EX<=stall?0:rs2_ID.
  - optype_MEM<=optype_EX; rd_MEM<=rd_EX.
- Load-use stall: stall=1 when optype_EX==LOAD and rd_EX!=0 and either condition holds:
  - rs1use_ID and rs1_ID==rd_EX, or
  - rs2use_ID and rs2_ID==rd_EX and hazard_optype_ID!=STORE.
  - The store-data case is covered by forward_ctrl_ls one cycle later, so it does not stall.
- Stall response:
  - PC_EN_IF=0, reg_FD_EN=0, reg_DE_flush=1.
  - reg_FD_flush forced 0 (stall wins over Branch_ID; the branch re-resolves next cycle with forwarded data).
  - stall_cnt increments by 1 per stall cycle and saturates at all-ones.
- No stall: PC_EN_IF=1, reg_FD_EN=1, reg_DE_flush=0, reg_FD_flush=Branch_ID.
- forward_ctrl_A, evaluated in priority order (x0 never forwarded; rs1use_ID=0 or rs1_ID==0 gives 0):
  - 1: rs1_ID==rd_EX and optype_EX==ALU.
  - 2: else rs1_ID==rd_MEM and optype_MEM==ALU.
  - 3: else rs1_ID==rd_MEM and optype_MEM==LOAD.
  - 0: otherwise.
- forward_ctrl_B: identical using rs2use_ID/rs2_ID.
- forward_ctrl_ls = (optype_EX==STORE) and (optype_MEM==LOAD) and rs2_EX!=0 and rs2_EX==rd_MEM.
- Optype NONE (0) and STORE in EX/MEM never produce a forward.
- Reset mid-stall: stall drops immediately, optype_EX cleared, stall_cnt=0.

Test Plan:
- Reset, then ADD x5 in ID followed by ADD using rs1=x5 -> next cycle forward_ctrl_A=1; one further unrelated instruction between them -> forward_ctrl_A=2.
- LW x6 then ADD rs2=x6 -> exactly one cycle with PC_EN_IF=0, reg_FD_EN=0, reg_DE_flush=1, stall_cnt 0->1; next cycle forward_ctrl_B=3, no stall.
- LW x6 then SW rs2=x6, rs1=x2 -> no stall; next cycle forward_ctrl_ls=1, forward_ctrl_B=0.
- LW x7 then BEQ x7,x0 with Branch_ID=1 during stall cycle -> reg_FD_flush=0, stall=1; following cycle Branch_ID=1 -> reg_FD_flush=1, PC_EN_IF=1.
- ADDI x0 then ADD rs1=x0; and LW x0 then ADD rs1=x0 -> forward_ctrl_A=0, no stall.
- CNT_W=2: five consecutive load-use pairs -> stall_cnt saturates at 3; assert rst mid-stall -> stall_cnt=0 and PC_EN_IF=1 asynchronously.
